ex_muldiv: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage, downstream of the ID/EX pipeline register. It consumes the latched operands and operation, computes MULT/MULTU/DIV/DIVU iteratively into the architectural HI/LO registers, and performs single-cycle MTHI/MTLO writes. It raises `stallE` to the hazard unit so the ID/EX register holds the instruction until the result is committed.

---
 rtl/ex_muldiv_pkg.sv | 14 +
 rtl/ex_muldiv_core.sv | 45 ++++
 rtl/ex_muldiv.sv | 74 +++++++
 tb/tb_ex_muldiv.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: op codes, shared constants and FSM state type for the EX-stage mul/div unit
package ex_muldiv_pkg;
   localparam int MD_OP_LENGTH = 3;
   localparam int MD_WIDTH = 32;
   localparam logic [MD_OP_LENGTH-1:0] MD_MULT  = 3'd0;
   localparam logic [MD_OP_LENGTH-1:0] MD_MULTU = 3'd1;
   localparam logic [MD_OP_LENGTH-1:0] MD_DIV   = 3'd2;
   localparam logic [MD_OP_LENGTH-1:0] MD_DIVU  = 3'd3;
   localparam logic [MD_OP_LENGTH-1:0] MD_MTHI  = 3'd4;
   localparam logic [MD_OP_LENGTH-1:0] MD_MTLO  = 3'd5;
   localparam logic [MD_WIDTH-1:0] ZERO_WORD = '0;
   localparam logic [MD_WIDTH-1:0] MD_DIV0_LO = '1;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
endpackage

// File: rtl/ex_muldiv_core.sv
// ex_muldiv_core: radix-2 shift-add multiply / restoring divide datapath on operand magnitudes,
// with sign fix-up applied to the value the current step produces so the final step commits directly.
module ex_muldiv_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic             neg_q,
   input  logic             neg_r,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);
   logic [2*WIDTH-1:0] acc, acc_nx, prod;
   logic [WIDTH-1:0]   m, quo, rem;
   logic [WIDTH:0]     sum, r, diff;
   always_comb begin
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};
      r = acc[2*WIDTH-1:WIDTH-1];
      diff = r - {1'b0, m};
      // diff[WIDTH] set means the trial subtraction borrowed: keep the shifted remainder
      acc_nx = is_div ? (diff[WIDTH] ? {r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                      : (acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});
      prod = neg_q ? -acc_nx : acc_nx;
      quo = acc_nx[WIDTH-1:0];
      rem = acc_nx[2*WIDTH-1:WIDTH];
      res_hi = is_div ? (neg_r ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
      res_lo = is_div ? (neg_q ? -quo : quo) : prod[WIDTH-1:0];
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         acc <= '0;
         m <= '0;
      end else if (load) begin
         acc <= {{WIDTH{1'b0}}, a};
         m <= b;
      end else if (step) begin
         acc <= acc_nx;
      end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO into HI/LO,
// stalling the ID/EX register until the result commits.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    startE,
   input  logic [MD_OP_LENGTH-1:0] mdOpE,
   input  logic [WIDTH-1:0]        srcAE,
   input  logic [WIDTH-1:0]        srcBE,
   input  logic                    cancelE,
   output logic [WIDTH-1:0]        hi,
   output logic [WIDTH-1:0]        lo,
   output logic                    stallE,
   output logic                    doneE
);
   localparam int CW = $clog2(WIDTH);
   md_state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic is_md, is_sgn, load, step, commit, wr_hi, wr_lo;
   logic is_div, neg_q, neg_r;
   logic [WIDTH-1:0] mag_a, mag_b, res_hi, res_lo;
   always_comb begin
      is_md = mdOpE inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
      is_sgn = mdOpE == MD_MULT || mdOpE == MD_DIV;
      mag_a = (is_sgn && srcAE[WIDTH-1]) ? -srcAE : srcAE;
      mag_b = (is_sgn && srcBE[WIDTH-1]) ? -srcBE : srcBE;
      load = state == IDLE && startE && is_md;
      wr_hi = state == IDLE && startE && mdOpE == MD_MTHI;
      wr_lo = state == IDLE && startE && mdOpE == MD_MTLO;
      step = state == BUSY && !cancelE;
      commit = step && cnt == '0;
      stallE = load || state == BUSY;
      doneE = state == DONE;
      state_nx = load ? BUSY : state == BUSY ? (cancelE ? IDLE : commit ? DONE : BUSY) : IDLE;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         hi <= ZERO_WORD;
         lo <= ZERO_WORD;
         is_div <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= load ? CW'(WIDTH-1) : step ? cnt - CW'(1) : cnt;
         if (load) begin
            is_div <= mdOpE == MD_DIV || mdOpE == MD_DIVU;
            // a zero divisor must leave the all-ones quotient unnegated and the remainder equal to the dividend
            neg_q <= is_sgn && (srcAE[WIDTH-1] ^ srcBE[WIDTH-1]) && |srcBE;
            neg_r <= is_sgn && srcAE[WIDTH-1];
         end
         hi <= commit ? res_hi : wr_hi ? srcAE : hi;
         lo <= commit ? res_lo : wr_lo ? srcAE : lo;
      end
   ex_muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk(clk),
      .rst(rst),
      .load(load),
      .step(step),
      .is_div(is_div),
      .neg_q(neg_q),
      .neg_r(neg_r),
      .a(mag_a),
      .b(mag_b),
      .res_hi(res_hi),
      .res_lo(res_lo)
   );
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors, random ops against an arithmetic model, and cancel/reset/DONE corner sequences.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;
   logic clk = 1'b0;
   logic rst, startE, cancelE, stallE, doneE;
   logic [2:0] mdOpE;
   logic [31:0] srcAE, srcBE, hi, lo;
   int tests = 0, fails = 0;
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs[9];

   ex_muldiv dut (
      .clk(clk), .rst(rst), .startE(startE), .mdOpE(mdOpE), .srcAE(srcAE), .srcBE(srcBE),
      .cancelE(cancelE), .hi(hi), .lo(lo), .stallE(stallE), .doneE(doneE)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      if ((op == MD_DIV || op == MD_DIVU) && b == 0) return {a, 32'hFFFFFFFF};
      if (op == MD_MULT) return 64'(sa * sb);
      if (op == MD_MULTU) return ua * ub;
      if (op == MD_DIV) begin
         q = sa / sb;
         r = sa % sb;
         return {r[31:0], q[31:0]};
      end
      uq = ua / ub;
      ur = ua % ub;
      return {ur[31:0], uq[31:0]};
   endfunction

   // Starts on a falling edge; holds the instruction in EX until it leaves after the DONE cycle.
   task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
      int stalls = 0, dones = 0, done_cyc = -1;
      startE = 1'b1; mdOpE = op; srcAE = a; srcBE = b;
      for (int c = 0; c < 36; c++) begin
         if (c == 34) startE = 1'b0;
         #1;
         stalls += int'(stallE);
         if (doneE === 1'b1) begin
            dones++;
            done_cyc = c;
            chk({name, " hilo"}, {hi, lo}, exp);
         end
         @(negedge clk);
      end
      chk({name, " stall cycles"}, 64'(stalls), 64'd33);
      chk({name, " done pulses"}, 64'(dones), 64'd1);
      chk({name, " done cycle"}, 64'(done_cyc), 64'd33);
   endtask

   task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
      startE = 1'b1; mdOpE = MD_MTHI; srcAE = h;
      @(negedge clk);
      mdOpE = MD_MTLO; srcAE = l;
      @(negedge clk);
      startE = 1'b0;
   endtask

   initial begin
      int dones;
      logic got;
      logic [2:0] op;
      logic [31:0] a, b;
      vecs = '{
         '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA},
         '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001},
         '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD},
         '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000},
         '{MD_DIVU,  32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF},
         '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF},
         '{MD_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E},
         '{MD_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD},
         '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001}
      };
      rst = 1'b0; startE = 1'b0; cancelE = 1'b0; mdOpE = MD_MULT; srcAE = '0; srcBE = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset hilo", {hi, lo}, 64'd0);
      chk("reset stall/done", {62'd0, stallE, doneE}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      startE = 1'b1; mdOpE = MD_MTHI; srcAE = 32'h12345678;
      #1;
      chk("mthi stall", 64'(stallE), 64'd0);
      @(negedge clk);
      mdOpE = MD_MTLO; srcAE = 32'h9ABCDEF0;
      #1;
      chk("mthi hi", 64'(hi), 64'h12345678);
      chk("mtlo stall", 64'(stallE), 64'd0);
      @(negedge clk);
      startE = 1'b0;
      #1;
      chk("mtlo hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
      @(negedge clk);

      foreach (vecs[i]) run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

      startE = 1'b1; mdOpE = MD_MULTU; srcAE = 32'd3; srcBE = 32'd5;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         #1;
         got = doneE;
      end
      chk("done seen", 64'(got), 64'd1);
      mdOpE = MD_MTLO; srcAE = 32'hDEADBEEF;
      #1;
      chk("mtlo in done stall", 64'(stallE), 64'd0);
      @(negedge clk);
      startE = 1'b0;
      #1;
      chk("mtlo in done ignored", {hi, lo}, 64'd15);
      chk("idle after done", {62'd0, stallE, doneE}, 64'd0);
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         op = 3'($urandom_range(0, 3));
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
         run_md($sformatf("rnd%0d op%0d", i, op), op, a, b, model(op, a, b));
      end

      write_hilo(32'h11111111, 32'h22222222);
      startE = 1'b1; mdOpE = MD_DIV; srcAE = 32'd100; srcBE = 32'd7;
      repeat (5) @(negedge clk);
      cancelE = 1'b1;
      @(negedge clk);
      cancelE = 1'b0; startE = 1'b0;
      #1;
      chk("cancel stall", 64'(stallE), 64'd0);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         dones += int'(doneE);
      end
      chk("cancel no done", 64'(dones), 64'd0);
      chk("cancel hilo kept", {hi, lo}, 64'h11111111_22222222);
      @(negedge clk);

      write_hilo(32'h55555555, 32'h66666666);
      startE = 1'b1; mdOpE = MD_MULT; srcAE = 32'd1234; srcBE = 32'd5678;
      repeat (10) @(negedge clk);
      #2;
      rst = 1'b0; startE = 1'b0;
      #1;
      chk("reset mid-op hilo", {hi, lo}, 64'd0);
      chk("reset mid-op stall", 64'(stallE), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         dones += int'(doneE) + int'(stallE);
      end
      chk("reset mid-op quiet", 64'(dones), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
